// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// A producer keeps its grant for up to MAX_BURST accepted beats, or until it drops req.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      full,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      write_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;

  logic [DATA_W-1:0]    data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   owner_oh;
  logic [NUM_REQ-1:0]   cand;
  logic [IDX_W:0]       pick;
  logic                 release_burst;

  // Index increment that wraps at NUM_REQ, so non-power-of-2 counts never reach a dead index.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // Returns {found, index} of the first set bit scanning start, start+1, ... modulo NUM_REQ.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   start);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    found = 1'b0;
    win   = '0;
    idx   = start;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && r[idx]) begin
        found = 1'b1;
        win   = idx;
      end
      idx = wrap_inc(idx);
    end
    return {found, win};
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign gnt      = gnt_q;
  assign busy     = (state_q == S_GRANT);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    beat_cnt_d    = beat_cnt_q;
    gnt_d         = gnt_q;
    cand          = req;
    pick          = '0;
    release_burst = 1'b0;
    write_en      = 1'b0;
    ack           = '0;
    wr_data       = '0;

    case (state_q)
      S_IDLE: begin
        pick = rr_pick(req, rr_ptr_q);
        if (pick[IDX_W]) begin
          state_d    = S_GRANT;
          owner_d    = pick[IDX_W-1:0];
          gnt_d      = NUM_REQ'(1) << pick[IDX_W-1:0];
          beat_cnt_d = '0;
        end
      end
      S_GRANT: begin
        write_en      = req[owner_q] & ~full;
        ack           = write_en ? owner_oh : '0;
        wr_data       = data_arr[owner_q];
        release_burst = write_en && (beat_cnt_q == LAST_BEAT);
        if (release_burst || !req[owner_q]) begin
          // A burst-limited owner sits out this handover; it regains the port via IDLE if alone.
          rr_ptr_d = wrap_inc(owner_q);
          cand     = release_burst ? (req & ~owner_oh) : req;
          pick     = rr_pick(cand, wrap_inc(owner_q));
          beat_cnt_d = '0;
          if (pick[IDX_W]) begin
            owner_d = pick[IDX_W-1:0];
            gnt_d   = NUM_REQ'(1) << pick[IDX_W-1:0];
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
          end
        end else if (write_en) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      gnt_q      <= gnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producers hold req until acked; a behavioural
// round-robin model predicts grant, ack, write strobe and data every cycle.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            full = 1'b0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            write_en;
  logic [DW-1:0]   wr_data;
  logic            busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .ack(ack), .write_en(write_en), .wr_data(wr_data), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int            pend [N];
  logic [DW-1:0] pdata [N];
  int            ack_seen [N];
  int            order_q [$];
  logic [N-1:0]  prev_gnt = '0;

  // Reference: who owns the port, how many beats it has written, where the scan starts.
  bit m_grant;
  int m_owner;
  int m_cnt;
  int m_ptr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_scan(input logic [N-1:0] r, input int start);
    int w;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (w < 0 && r[idx]) w = idx;
    end
    return w;
  endfunction

  function automatic bit any_pend();
    bit a;
    a = 1'b0;
    for (int i = 0; i < N; i++) if (pend[i] > 0) a = 1'b1;
    return a;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i] = (pend[i] > 0);
      req_data[i*DW +: DW] = pdata[i];
    end
  endtask

  task automatic model_reset();
    m_grant  = 1'b0;
    m_owner  = 0;
    m_cnt    = 0;
    m_ptr    = 0;
    prev_gnt = '0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic f);
    logic [N-1:0]  e_gnt;
    logic [N-1:0]  e_ack;
    logic          e_we;
    logic [DW-1:0] e_data;
    logic [N-1:0]  cand;
    bit            burst_done;
    int            w;
    full = f;
    drive_inputs();
    #1;
    e_gnt  = m_grant ? (4'b0001 << m_owner) : 4'b0000;
    e_we   = m_grant && req[m_owner] && !f;
    e_ack  = e_we ? e_gnt : 4'b0000;
    e_data = m_grant ? pdata[m_owner] : 8'h00;
    chk("gnt", 64'(gnt), 64'(e_gnt));
    chk("busy", 64'(busy), 64'(m_grant));
    chk("write_en", 64'(write_en), 64'(e_we));
    chk("ack", 64'(ack), 64'(e_ack));
    chk("wr_data", 64'(wr_data), 64'(e_data));

    if (gnt !== prev_gnt && gnt != '0) begin
      for (int i = 0; i < N; i++) if (gnt[i]) order_q.push_back(i);
    end
    prev_gnt = gnt;

    for (int i = 0; i < N; i++) begin
      if (ack[i] === 1'b1) begin
        ack_seen[i]++;
        if (pend[i] > 0) pend[i]--;
        pdata[i] = 8'($urandom);
      end
    end

    if (!m_grant) begin
      w = rr_scan(req, m_ptr);
      if (w >= 0) begin
        m_grant = 1'b1;
        m_owner = w;
        m_cnt   = 0;
      end
    end else begin
      burst_done = e_we && (m_cnt == MB - 1);
      if (burst_done || !req[m_owner]) begin
        m_ptr = (m_owner + 1) % N;
        cand  = req;
        if (burst_done) cand[m_owner] = 1'b0;
        w = rr_scan(cand, m_ptr);
        if (w >= 0) begin
          m_owner = w;
          m_cnt   = 0;
        end else begin
          m_grant = 1'b0;
        end
      end else if (e_we) begin
        m_cnt++;
      end
    end
    @(negedge clk);
  endtask

  // Asserted at a falling edge; the effect is checked before any clock edge.
  task automatic do_reset();
    drive_inputs();
    rst = 1'b1;
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_write_en", 64'(write_en), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ack", 64'(ack), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while ((any_pend() || m_grant) && k < max_cycles) begin
      cycle(1'b0);
      k++;
    end
    chk("drain_done", 64'(any_pend()), 64'h0);
  endtask

  task automatic clear_acks();
    for (int i = 0; i < N; i++) ack_seen[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend[i]     = 0;
      pdata[i]    = 8'($urandom);
      ack_seen[i] = 0;
    end
    @(negedge clk);

    // Reset with every producer requesting, then producer 0 wins first.
    for (int i = 0; i < N; i++) pend[i] = 1;
    do_reset();
    cycle(1'b0);
    drive_inputs();
    #1;
    chk("t1_first_gnt", 64'(gnt), 64'h1);
    drain(40);

    // Single producer, six beats: burst of four, one idle cycle, then two more.
    clear_acks();
    pend[2] = 6;
    drain(40);
    chk("t2_acks", 64'(ack_seen[2]), 64'd6);

    // All four requesting from reset: back-to-back bursts in order 0,1,2,3,0.
    for (int i = 0; i < N; i++) pend[i] = 5;
    do_reset();
    clear_acks();
    order_q.delete();
    for (int c = 0; c < 17; c++) cycle(1'b0);
    chk("t3_beats_17cyc", 64'(ack_seen[0] + ack_seen[1] + ack_seen[2] + ack_seen[3]), 64'd16);
    drain(60);
    chk("t3_order_len", 64'(order_q.size() >= 5), 64'h1);
    if (order_q.size() >= 5) begin
      chk("t3_order0", 64'(order_q[0]), 64'd0);
      chk("t3_order1", 64'(order_q[1]), 64'd1);
      chk("t3_order2", 64'(order_q[2]), 64'd2);
      chk("t3_order3", 64'(order_q[3]), 64'd3);
      chk("t3_order4", 64'(order_q[4]), 64'd0);
    end

    // Backpressure for three cycles after two beats; burst completes after two more.
    clear_acks();
    pend[1] = 4;
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    for (int c = 0; c < 3; c++) cycle(1'b1);
    chk("t4_frozen_acks", 64'(ack_seen[1]), 64'd2);
    cycle(1'b0);
    cycle(1'b0);
    chk("t4_acks", 64'(ack_seen[1]), 64'd4);
    cycle(1'b0);
    chk("t4_idle_after", 64'(busy), 64'h0);

    // Full rising exactly on the final beat holds the grant until it clears.
    pend[3] = 4;
    pend[0] = 2;
    for (int c = 0; c < 4; c++) cycle(1'b0);
    cycle(1'b1);
    cycle(1'b1);
    drain(40);

    // Owner 1 drops req after two beats; producer 3 takes over with no bubble.
    do_reset();
    pend[1] = 5;
    pend[3] = 3;
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b0);
    pend[1] = 0;
    cycle(1'b0);
    drive_inputs();
    #1;
    chk("t5_gnt", 64'(gnt), 64'h8);
    drain(40);

    // Reset in the middle of owner 2's burst; producer 0 wins afterwards.
    do_reset();
    pend[2] = 6;
    for (int c = 0; c < 4; c++) cycle(1'b0);
    pend[0] = 2;
    do_reset();
    cycle(1'b0);
    drive_inputs();
    #1;
    chk("t6_regrant", 64'(gnt), 64'h1);
    drain(60);

    // Randomized traffic and backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (pend[i] == 0 && $urandom_range(0, 3) == 0) pend[i] = $urandom_range(1, 7);
      cycle($urandom_range(0, 4) == 0);
    end
    drain(200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
